// File: rtl/ifmap_fetch_ctrl_pkg.sv
// Shared types and constants for the ifmap fetch controller and its per-lane credit counters.
package ifmap_pkg;

  localparam int unsigned NUM_LANES  = 32;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned CRED_W     = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned LANE_W     = $clog2(NUM_LANES);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } fsm_state_e;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [LANE_W-1:0] lowest_lane(input logic [NUM_LANES-1:0] v);
    logic [LANE_W-1:0] idx;
    logic              found;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if (v[i[LANE_W-1:0]] && !found) begin
        idx   = LANE_W'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/ifmap_fetch_ctrl_if.sv
// Descriptor, SRAM read port and FIFO-bank push/pop signals of the ifmap fetch controller.
interface ifmap_fetch_ctrl_if
  import ifmap_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned CNT_W  = 16
);

  logic                          start;
  logic [ADDR_W-1:0]             base_addr;
  logic [CNT_W-1:0]              words_per_lane;
  logic [NUM_LANES-1:0]          lane_mask;
  logic                          busy;
  logic                          done;
  logic                          sram_re;
  logic [ADDR_W-1:0]             sram_addr;
  logic [DATA_W-1:0]             sram_rdata;
  logic [NUM_LANES-1:0]          push;
  logic [NUM_LANES*DATA_W-1:0]   push_data;
  logic [NUM_LANES-1:0]          fifo_pop;
  logic [NUM_LANES-1:0]          fifo_not_empty;

  modport master (
    input  start, base_addr, words_per_lane, lane_mask,
    input  sram_rdata, fifo_pop, fifo_not_empty,
    output busy, done, sram_re, sram_addr, push, push_data
  );

  modport slave (
    output start, base_addr, words_per_lane, lane_mask,
    output sram_rdata, fifo_pop, fifo_not_empty,
    input  busy, done, sram_re, sram_addr, push, push_data
  );

endinterface

// File: rtl/ifmap_credit_ctr.sv
// Per-lane credit counter: starts full, -1 per issued read, +1 per effective FIFO pop.
module ifmap_credit_ctr
  import ifmap_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH,
  parameter int unsigned CW    = CRED_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dec,
  input  logic          inc,
  output logic [CW-1:0] credit,
  output logic          has_credit
);

  // Saturates at both ends; dec and inc together cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit <= CW'(DEPTH);
    end else if (dec && !inc && credit != '0) begin
      credit <= credit - CW'(1);
    end else if (inc && !dec && credit != CW'(DEPTH)) begin
      credit <= credit + CW'(1);
    end
  end

  assign has_credit = (credit != '0);

endmodule

// File: rtl/ifmap_fetch_ctrl.sv
// Fetches lane-interleaved ifmap words from SRAM and pushes each into its lane FIFO under credit flow control.
module ifmap_fetch_ctrl
  import ifmap_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  ifmap_fetch_ctrl_if.master bus
);

  fsm_state_e           state, state_n;
  logic [ADDR_W-1:0]    base_q;
  logic [CNT_W-1:0]     wpl_q, k_q, k_n;
  logic [NUM_LANES-1:0] mask_q, above;
  logic [LANE_W-1:0]    lane_q, lane_n, push_lane_q;
  logic                 push_vld_q;
  logic                 accept, issue, last_lane, last_k;
  logic [NUM_LANES-1:0] dec_vec, inc_vec, has_credit;
  logic [CRED_W-1:0]    credit_w [NUM_LANES];
  logic [DATA_W-1:0]    rdata;

  assign accept    = (state == IDLE) && bus.start;
  assign issue     = (state == FETCH) && has_credit[lane_q];
  // Enabled lanes strictly above the current one.
  assign above     = mask_q & ~((NUM_LANES'(2) << lane_q) - NUM_LANES'(1));
  assign last_lane = (above == '0);
  assign last_k    = (k_q == wpl_q - CNT_W'(1));

  always_comb begin
    state_n = state;
    k_n     = k_q;
    lane_n  = lane_q;
    case (state)
      IDLE: begin
        if (bus.start) begin
          k_n     = '0;
          lane_n  = lowest_lane(bus.lane_mask);
          state_n = (bus.words_per_lane == '0 || bus.lane_mask == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        if (issue) begin
          if (!last_lane) begin
            lane_n = lowest_lane(above);
          end else begin
            lane_n = lowest_lane(mask_q);
            k_n    = k_q + CNT_W'(1);
            if (last_k) state_n = DRAIN;
          end
        end
      end
      DRAIN:   state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      base_q      <= '0;
      wpl_q       <= '0;
      mask_q      <= '0;
      k_q         <= '0;
      lane_q      <= '0;
      push_vld_q  <= 1'b0;
      push_lane_q <= '0;
    end else begin
      state      <= state_n;
      k_q        <= k_n;
      lane_q     <= lane_n;
      push_vld_q <= issue;
      if (issue) push_lane_q <= lane_q;
      if (accept) begin
        base_q <= bus.base_addr;
        wpl_q  <= bus.words_per_lane;
        mask_q <= bus.lane_mask;
      end
    end
  end

  always_comb begin
    dec_vec = '0;
    if (issue) dec_vec[lane_q] = 1'b1;
  end

  assign inc_vec = bus.fifo_pop & bus.fifo_not_empty;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    ifmap_credit_ctr #(
      .DEPTH (FIFO_DEPTH),
      .CW    (CRED_W)
    ) u_cred (
      .clk        (clk),
      .rst        (rst),
      .dec        (dec_vec[i]),
      .inc        (inc_vec[i]),
      .credit     (credit_w[i]),
      .has_credit (has_credit[i])
    );

    // A pop at full credit means the bank popped a word it was never sent.
    a_no_overpop: assert property (@(posedge clk) disable iff (rst)
      !(inc_vec[i] && !dec_vec[i] && credit_w[i] == CRED_W'(FIFO_DEPTH)));
  end

  assign rdata         = bus.sram_rdata;
  assign bus.busy      = (state == FETCH) || (state == DRAIN);
  assign bus.done      = (state == DONE);
  assign bus.sram_re   = issue;
  assign bus.sram_addr = base_q + (ADDR_W'(k_q) << LANE_W) + ADDR_W'(lane_q);
  assign bus.push      = push_vld_q ? (NUM_LANES'(1) << push_lane_q) : '0;
  assign bus.push_data = {NUM_LANES{rdata}};

endmodule

// File: tb/tb_ifmap_fetch_ctrl.sv
// Bench for ifmap_fetch_ctrl: queue-based reference model checked every cycle, plus literal expectations per scenario.
module tb_ifmap_fetch_ctrl;

  localparam int NL    = 32;
  localparam int DEPTH = 4;
  localparam int P_IDLE = 0, P_RUN = 1, P_DRAIN = 2, P_DONE = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ifmap_fetch_ctrl_if #(.DATA_W(32), .ADDR_W(16), .CNT_W(16)) bus ();

  ifmap_fetch_ctrl #(.DATA_W(32), .ADDR_W(16), .CNT_W(16)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] word_of(input logic [15:0] a);
    return {a ^ 16'h5A5A, a};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // SRAM: data one cycle after the read
  always @(posedge clk) if (bus.sram_re) bus.sram_rdata <= word_of(bus.sram_addr);

  // FIFO bank occupancy, reset together with the controller
  int occ [NL];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NL; i++) occ[i] <= 0;
    end else begin
      for (int i = 0; i < NL; i++)
        occ[i] <= occ[i] + (bus.push[i] ? 1 : 0) - ((bus.fifo_pop[i] && occ[i] > 0) ? 1 : 0);
    end
  end
  always_comb begin
    for (int i = 0; i < NL; i++) bus.fifo_not_empty[i] = (occ[i] > 0);
  end

  // Reference model: the descriptor expands into an ordered list of reads.
  typedef struct {
    int          lane;
    logic [15:0] addr;
  } item_t;

  item_t       expq[$];
  item_t       pend;
  item_t       it;
  logic        pend_v = 1'b0;
  int          phase  = P_IDLE;
  logic        exp_re;
  logic [31:0] exp_push;
  logic [31:0] pd_exp;
  int          cred, sel;

  logic [15:0] act_log[$];
  int unsigned act_cyc[$];
  int          push_cnt = 0;
  bit          done_seen = 0;
  int unsigned done_cyc = 0;
  int unsigned start_cyc = 0;

  always @(negedge clk) begin
    #2;
    if (rst) begin
      phase  = P_IDLE;
      pend_v = 1'b0;
      expq.delete();
      check("rst_busy",      bus.busy,      64'd0);
      check("rst_done",      bus.done,      64'd0);
      check("rst_sram_re",   bus.sram_re,   64'd0);
      check("rst_sram_addr", bus.sram_addr, 64'd0);
      check("rst_push",      bus.push,      64'd0);
    end else begin
      exp_re = 1'b0;
      if (phase == P_RUN) begin
        cred   = DEPTH - occ[expq[0].lane] - ((pend_v && pend.lane == expq[0].lane) ? 1 : 0);
        exp_re = (cred > 0);
      end
      check("sram_re", bus.sram_re, exp_re);
      if (exp_re) check("sram_addr", bus.sram_addr, expq[0].addr);
      exp_push = pend_v ? (32'd1 << pend.lane) : 32'd0;
      check("push", bus.push, exp_push);
      if (pend_v) begin
        pd_exp = word_of(pend.addr);
        sel    = 0;
        for (int l = 0; l < NL; l++) if (bus.push_data[l*32 +: 32] !== pd_exp) sel = l;
        check("push_data", bus.push_data[sel*32 +: 32], pd_exp);
      end
      check("busy", bus.busy, (phase == P_RUN || phase == P_DRAIN));
      check("done", bus.done, (phase == P_DONE));

      if (bus.sram_re) begin
        act_log.push_back(bus.sram_addr);
        act_cyc.push_back(cyc);
      end
      if (bus.push != '0) push_cnt++;
      if (bus.done) begin
        done_seen = 1;
        done_cyc  = cyc;
      end

      case (phase)
        P_IDLE: begin
          pend_v = 1'b0;
          if (bus.start) begin
            for (int k = 0; k < int'(bus.words_per_lane); k++)
              for (int l = 0; l < NL; l++)
                if (bus.lane_mask[l]) begin
                  it.lane = l;
                  it.addr = 16'(int'(bus.base_addr) + k * NL + l);
                  expq.push_back(it);
                end
            phase = (expq.size() == 0) ? P_DONE : P_RUN;
          end
        end
        P_RUN: begin
          pend_v = exp_re;
          if (exp_re) begin
            pend = expq.pop_front();
            if (expq.size() == 0) phase = P_DRAIN;
          end
        end
        P_DRAIN: begin
          pend_v = 1'b0;
          phase  = P_DONE;
        end
        default: begin
          pend_v = 1'b0;
          phase  = P_IDLE;
        end
      endcase
    end
  end

  // Stimulus
  logic        auto_pop = 1'b0;
  logic [31:0] man_pop  = '0;

  task automatic step();
    @(negedge clk);
    bus.fifo_pop = auto_pop ? bus.fifo_not_empty : man_pop;
  endtask

  task automatic do_start(input logic [15:0] b, input logic [15:0] w, input logic [31:0] m);
    step();
    bus.base_addr      = b;
    bus.words_per_lane = w;
    bus.lane_mask      = m;
    bus.start          = 1'b1;
    start_cyc          = cyc;
    done_seen          = 0;
    step();
    bus.start = 1'b0;
  endtask

  task automatic clear_logs();
    act_log.delete();
    act_cyc.delete();
    push_cnt = 0;
  endtask

  task automatic wait_done(input string name, input int budget);
    for (int i = 0; i < budget && !done_seen; i++) step();
    check(name, done_seen, 64'd1);
  endtask

  task automatic drain();
    auto_pop = 1'b1;
    repeat (8) step();
    auto_pop = 1'b0;
    step();
  endtask

  initial begin
    bus.start          = 1'b0;
    bus.base_addr      = '0;
    bus.words_per_lane = '0;
    bus.lane_mask      = '0;
    bus.fifo_pop       = '0;
    repeat (3) step();
    rst = 1'b0;
    repeat (2) step();

    // single lane, no pops
    clear_logs();
    do_start(16'h100, 16'd3, 32'h1);
    wait_done("t1_done", 40);
    check("t1_n",    act_log.size(), 3);
    check("t1_a0",   act_log[0], 16'h100);
    check("t1_a1",   act_log[1], 16'h120);
    check("t1_a2",   act_log[2], 16'h140);
    check("t1_push", push_cnt, 3);
    drain();

    // full mask with continuous pops; a second start mid-run must be ignored
    clear_logs();
    auto_pop = 1'b1;
    do_start(16'h2000, 16'd1, 32'hFFFF_FFFF);
    for (int i = 0; i < 40 && act_log.size() < 5; i++) step();
    do_start(16'h7000, 16'd5, 32'h1);
    wait_done("t2_done", 80);
    check("t2_n",     act_log.size(), 32);
    check("t2_first", act_log[0], 16'h2000);
    check("t2_last",  act_log[31], 16'h201F);
    check("t2_b2b",   act_cyc[31] - act_cyc[0], 31);
    check("t2_lat",   done_cyc - act_cyc[31], 2);
    repeat (6) step();
    check("t2_ignored", act_log.size(), 32);
    drain();

    // credit stall on lane 0, then two pops release two more reads
    clear_logs();
    do_start(16'h40, 16'd6, 32'h1);
    repeat (10) step();
    check("t3_stall_n", act_log.size(), 4);
    man_pop = 32'h1;
    repeat (2) step();
    man_pop = '0;
    wait_done("t3_done", 40);
    check("t3_n",    act_log.size(), 6);
    check("t3_last", act_log[5], 16'hE0);
    // lane 0 credit is now exhausted
    clear_logs();
    do_start(16'h0, 16'd1, 32'h1);
    repeat (6) step();
    check("t3_zero_credit", act_log.size(), 0);
    auto_pop = 1'b1;
    wait_done("t3b_done", 40);
    check("t3b_n", act_log.size(), 1);
    drain();

    // issue and pop on the same lane keep throughput at one word per cycle
    clear_logs();
    auto_pop = 1'b1;
    do_start(16'h300, 16'd8, 32'h1);
    wait_done("t4_done", 60);
    check("t4_n",    act_log.size(), 8);
    check("t4_b2b",  act_cyc[7] - act_cyc[0], 7);
    check("t4_last", act_log[7], 16'h3E0);
    drain();

    // sparse mask
    clear_logs();
    auto_pop = 1'b1;
    do_start(16'h0, 16'd2, 32'h8000_0001);
    wait_done("t5_done", 40);
    check("t5_n",  act_log.size(), 4);
    check("t5_a0", act_log[0], 16'd0);
    check("t5_a1", act_log[1], 16'd31);
    check("t5_a2", act_log[2], 16'd32);
    check("t5_a3", act_log[3], 16'd63);
    drain();

    // empty descriptors
    clear_logs();
    do_start(16'h55, 16'd0, 32'hFF);
    wait_done("t6_done", 10);
    check("t6_lat", done_cyc - start_cyc, 1);
    check("t6_n",   act_log.size(), 0);
    do_start(16'h55, 16'd3, 32'h0);
    wait_done("t6b_done", 10);
    check("t6b_lat", done_cyc - start_cyc, 1);
    check("t6b_n",   act_log.size(), 0);
    repeat (2) step();

    // reset after five issues
    clear_logs();
    do_start(16'h200, 16'd4, 32'hF);
    for (int i = 0; i < 30 && act_log.size() < 5; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t7_n", act_log.size(), 5);
    clear_logs();
    do_start(16'h0, 16'd4, 32'hF);
    wait_done("t7_done", 40);
    check("t7_full_n", act_log.size(), 16);
    check("t7_b2b",    act_cyc[15] - act_cyc[0], 15);
    drain();
    clear_logs();
    auto_pop = 1'b1;
    do_start(16'h10, 16'd2, 32'h3);
    wait_done("t8_done", 40);
    check("t8_n",  act_log.size(), 4);
    check("t8_a0", act_log[0], 16'h10);
    check("t8_a1", act_log[1], 16'h11);
    check("t8_a2", act_log[2], 16'h30);
    check("t8_a3", act_log[3], 16'h31);
    auto_pop = 1'b0;
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, got cycle %0d, want < 10000", cyc);
    $fatal(1);
  end

endmodule
